// File: rtl/wi23_defs.sv
// Shared data-port widths, MMIO map and STATUS layout for the data-memory responder.
package wi23_defs;

  localparam int unsigned DMEM_WIDTH = 32;
  localparam int unsigned TX_BYTE_W  = 8;
  localparam int unsigned MMIO_OFF_W = 4;

  localparam logic [DMEM_WIDTH-1:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [MMIO_OFF_W-1:0] OFF_CYCLE  = 4'h0;
  localparam logic [MMIO_OFF_W-1:0] OFF_STATUS = 4'h4;
  localparam logic [MMIO_OFF_W-1:0] OFF_TXDATA = 4'h8;
  localparam logic [MMIO_OFF_W-1:0] OFF_CTRL   = 4'hC;

  localparam int unsigned STATUS_OVF_BIT   = 7;
  localparam int unsigned STATUS_FULL_BIT  = 6;
  localparam int unsigned STATUS_EMPTY_BIT = 5;
  localparam int unsigned STATUS_COUNT_LSB = 0;
  localparam int unsigned STATUS_COUNT_W   = 5;

  typedef struct packed {
    logic [DMEM_WIDTH-1:0] addr;
    logic [DMEM_WIDTH-1:0] wdata;
    logic                  we;
    logic                  re;
  } dmem_req_t;

  // Assemble the STATUS read word from its individual fields.
  function automatic logic [DMEM_WIDTH-1:0] status_word(
    input logic                      ovf,
    input logic                      full,
    input logic                      empty,
    input logic [STATUS_COUNT_W-1:0] count
  );
    logic [DMEM_WIDTH-1:0] w;
    w = '0;
    w[STATUS_OVF_BIT]   = ovf;
    w[STATUS_FULL_BIT]  = full;
    w[STATUS_EMPTY_BIT] = empty;
    w[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO whose head word, valid, full and empty flags all come straight from flops.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [WIDTH-1:0] data_q, head_n;
  logic             valid_q, full_q, empty_q;
  logic             push_ok, pop_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_ok  = pop & valid_q;
    push_ok = push & (~full_q | pop_ok);
    rd_n    = rd_ptr_q + PTR_W'(pop_ok);
    count_n = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    head_n  = mem[rd_n];
    // The new head is the word being written when it lands on the next read slot.
    if (push_ok && (wr_ptr_q == rd_n)) begin
      head_n = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_q <= rd_n;
      count_q  <= count_n;
      data_q   <= head_n;
      valid_q  <= (count_n != '0);
      full_q   <= (count_n == CNT_W'(DEPTH));
      empty_q  <= (count_n == '0);
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/dmem_responder.sv
// Processor data-port responder: word RAM, free-running cycle counter and a byte TX FIFO behind MMIO.
module dmem_responder
  import wi23_defs::*;
#(
  parameter int unsigned           RAM_WORDS  = 4096,
  parameter int unsigned           FIFO_DEPTH = 8,
  parameter logic [DMEM_WIDTH-1:0] CYCLE_INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DMEM_WIDTH-1:0] daddr_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DMEM_WIDTH-1:0] wdata_i,
  output logic [DMEM_WIDTH-1:0] rdata_o,
  input  logic                  halt_i,
  output logic [TX_BYTE_W-1:0]  tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  err_o
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  dmem_req_t              req;
  logic                   sel_ram, sel_cycle, sel_status, sel_tx, sel_ctrl, sel_bad;
  logic                   in_ram, in_mmio;
  logic [RAM_AW-1:0]      ram_idx;
  logic [DMEM_WIDTH-1:0]  ram [RAM_WORDS];
  logic [DMEM_WIDTH-1:0]  cycle_q;
  logic                   ovf_q, err_q;
  logic                   push_c, pop_c, overflow_c, ovf_clr_c;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  assign req     = '{addr: daddr_i, wdata: wdata_i, we: we_i, re: re_i};
  assign ram_idx = req.addr[RAM_AW+1:2];

  // Address decode: at most one select is high, and only while an access is requested.
  always_comb begin
    sel_ram    = 1'b0;
    sel_cycle  = 1'b0;
    sel_status = 1'b0;
    sel_tx     = 1'b0;
    sel_ctrl   = 1'b0;
    sel_bad    = 1'b0;
    in_ram     = (req.addr[DMEM_WIDTH-1:RAM_AW+2] == '0);
    in_mmio    = (req.addr[DMEM_WIDTH-1:MMIO_OFF_W] == MMIO_BASE[DMEM_WIDTH-1:MMIO_OFF_W]);
    if (req.we || req.re) begin
      if ((req.we && req.re) || (req.addr[1:0] != 2'b00)) begin
        sel_bad = 1'b1;
      end else if (in_ram) begin
        sel_ram = 1'b1;
      end else if (in_mmio) begin
        case (req.addr[MMIO_OFF_W-1:0])
          OFF_CYCLE:  if (req.re) sel_cycle  = 1'b1; else sel_bad = 1'b1;
          OFF_STATUS: if (req.re) sel_status = 1'b1; else sel_bad = 1'b1;
          OFF_TXDATA: if (req.we) sel_tx     = 1'b1; else sel_bad = 1'b1;
          OFF_CTRL:   if (req.we) sel_ctrl   = 1'b1; else sel_bad = 1'b1;
          default:    sel_bad = 1'b1;
        endcase
      end else begin
        sel_bad = 1'b1;
      end
    end
  end

  // Word RAM: asynchronous read, write on the edge, deliberately not reset.
  always_ff @(posedge clk) begin
    if (req.we && sel_ram) begin
      ram[ram_idx] <= req.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= CYCLE_INIT;
    end else if (!halt_i) begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign pop_c      = tx_valid_o & tx_ready_i;
  assign push_c     = req.we & sel_tx;
  assign overflow_c = push_c & fifo_full & ~pop_c;
  assign ovf_clr_c  = req.we & sel_ctrl & req.wdata[0];

  sync_fifo #(
    .WIDTH (TX_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (req.wdata[TX_BYTE_W-1:0]),
    .pop       (pop_c),
    .data      (tx_data_o),
    .valid     (tx_valid_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow flag; a same-cycle overflow beats a CTRL clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= sel_bad;
      if (overflow_c) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_c) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign err_o = err_q;

  always_comb begin
    rdata_o = '0;
    if (req.re) begin
      if (sel_ram) begin
        rdata_o = ram[ram_idx];
      end else if (sel_cycle) begin
        rdata_o = cycle_q;
      end else if (sel_status) begin
        rdata_o = status_word(ovf_q, fifo_full, fifo_empty, STATUS_COUNT_W'(fifo_count));
      end
    end
  end

endmodule
